// File: rtl/antares_memory_responder_if.sv
// Antares enable/ready/error bus bundle between an initiator (CPU port) and a memory responder.
interface antares_memory_responder_if;
    logic [31:0] port_address;
    logic [31:0] port_data_i;
    logic [3:0]  port_wr;
    logic        port_enable;
    logic [31:0] port_data_o;
    logic        port_ready;
    logic        port_error;

    // Handshake: the initiator raises port_enable with a stable request and holds it until it
    // samples a one-cycle port_ready (done) or port_error (decode miss); the two never coincide.
    modport master (
        output port_address, port_data_i, port_wr, port_enable,
        input  port_data_o, port_ready, port_error
    );
    modport slave (
        input  port_address, port_data_i, port_wr, port_enable,
        output port_data_o, port_ready, port_error
    );
endinterface

// File: rtl/antares_memory_responder.sv
// On-chip memory responder with programmable wait states, byte-lane writes and out-of-range error.
// Optional macro ANTARES_MEM_ABORT_EN: dropping port_enable during WAIT abandons the request.
module antares_memory_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    antares_memory_responder_if.slave   bus,
    output logic [1:0]                  state_dbg
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2, S_ERR = 2'd3} state_t;

    state_t                  state, state_next;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [3:0]              lat_wr;
    logic [31:0]             lat_data;
    logic [31:0]             data_q;
    logic [31:0]             mem [DEPTH];

    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   live_idx;
    logic [ADDR_WIDTH-1:0]   eff_idx;
    logic [3:0]              eff_wr;
    logic [31:0]             eff_data;
    logic                    resp_entry;
    logic                    unused_addr_lsb;

    assign in_range        = (bus.port_address[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign live_idx        = bus.port_address[ADDR_WIDTH+1:2];
    assign unused_addr_lsb = ^bus.port_address[1:0];

    // With zero wait states RESP is entered straight from IDLE, so the live request is used there.
    assign eff_idx  = (state == S_IDLE) ? live_idx        : lat_idx;
    assign eff_wr   = (state == S_IDLE) ? bus.port_wr     : lat_wr;
    assign eff_data = (state == S_IDLE) ? bus.port_data_i : lat_data;

    assign resp_entry = !rst && (state != S_RESP) && (state_next == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.port_enable) begin
                    if (!in_range)             state_next = S_ERR;
                    else if (WAIT_STATES == 0) state_next = S_RESP;
                    else                       state_next = S_WAIT;
                end
            end
            S_WAIT: begin
`ifdef ANTARES_MEM_ABORT_EN
                if (!bus.port_enable) state_next = S_IDLE;
                else if (cnt == 4'd0) state_next = S_RESP;
`else
                if (cnt == 4'd0) state_next = S_RESP;
`endif
            end
            S_RESP:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.port_ready = (state == S_RESP);
        bus.port_error = (state == S_ERR);
        state_dbg      = state;
    end

    assign bus.port_data_o = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_wr   <= 4'd0;
            lat_data <= 32'd0;
            data_q   <= 32'd0;
        end else begin
            if (state == S_IDLE && bus.port_enable && in_range) begin
                lat_idx  <= live_idx;
                lat_wr   <= bus.port_wr;
                lat_data <= bus.port_data_i;
                cnt      <= WS_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (resp_entry && eff_wr == 4'd0) data_q <= mem[eff_idx];
        end
    end

    // Array contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (resp_entry) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_wr[i]) mem[eff_idx][8*i +: 8] <= eff_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_antares_memory_responder.sv
// Bench: a 2-wait-state responder and a 0-wait-state responder sharing one request driver.
module tb_antares_memory_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wr = 4'd0;
    logic        en = 1'b0;
    logic        use_ws0 = 1'b0;
    logic [1:0]  dbg0, dbg2;

    int total = 0;
    int bad = 0;

    antares_memory_responder_if b0();
    antares_memory_responder_if b2();

    assign b0.port_address = addr;
    assign b0.port_data_i  = wdata;
    assign b0.port_wr      = wr;
    assign b0.port_enable  = en && use_ws0;
    assign b2.port_address = addr;
    assign b2.port_data_i  = wdata;
    assign b2.port_wr      = wr;
    assign b2.port_enable  = en && !use_ws0;

    antares_memory_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave), .state_dbg(dbg0));
    antares_memory_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave), .state_dbg(dbg2));

    logic        obs_ready, obs_error;
    logic [31:0] obs_data;
    assign obs_ready = use_ws0 ? b0.port_ready  : b2.port_ready;
    assign obs_error = use_ws0 ? b0.port_error  : b2.port_error;
    assign obs_data  = use_ws0 ? b0.port_data_o : b2.port_data_o;

    always #5 clk = ~clk;

    // Reference model: index 0 -> dut2, index 1 -> dut0.
    logic [31:0] mdl [2][1024];
    logic [31:0] last_rd [2];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] lanes);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic do_txn(input logic s, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] d, output int lat, output logic err,
                          output logic both, output logic [31:0] rd, output logic pulse_ok);
        logic got = 1'b0;
        @(negedge clk);
        use_ws0 = s; addr = a; wr = w; wdata = d; en = 1'b1;
        lat = 0; both = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (obs_ready || obs_error) got = 1'b1;
        end
        err  = obs_error;
        both = obs_ready && obs_error;
        rd   = obs_data;
        en   = 1'b0;
        @(posedge clk); #1;
        pulse_ok = !obs_ready && !obs_error;
    endtask

    task automatic test_reset();
        total++; if (b2.port_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", b2.port_ready); end
        total++; if (b2.port_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", b2.port_error); end
        total++; if (b2.port_data_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", b2.port_data_o); end
        total++; if (dbg2 !== 2'd0 || dbg0 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0", dbg2, dbg0); end
        total++; if (b0.port_data_o !== 32'd0) begin bad++; $display("FAIL reset_data0 got=%h exp=0", b0.port_data_o); end
    endtask

    task automatic test_word_write_read();
        int lat; logic err, both, pok; logic [31:0] rd;
        do_txn(1'b0, 32'h100, 4'hF, 32'hDEADBEEF, lat, err, both, rd, pok);
        mdl[0][64] = 32'hDEADBEEF;
        total++; if (lat !== 3 || err !== 1'b0) begin bad++; $display("FAIL wr_latency got=%0d err=%b exp=3 err=0", lat, err); end
        total++; if (pok !== 1'b1) begin bad++; $display("FAIL wr_pulse got=%b exp=1", pok); end
        do_txn(1'b0, 32'h100, 4'h0, 32'h0, lat, err, both, rd, pok);
        total++; if (lat !== 3 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_word got=%h lat=%0d exp=deadbeef lat=3", rd, lat); end
        last_rd[0] = rd;
    endtask

    task automatic test_byte_lanes();
        int lat; logic err, both, pok; logic [31:0] rd;
        do_txn(1'b0, 32'h102, 4'b0100, 32'h00AB0000, lat, err, both, rd, pok);
        mdl[0][64] = merge(mdl[0][64], 32'h00AB0000, 4'b0100);
        do_txn(1'b0, 32'h100, 4'b0011, 32'h00001234, lat, err, both, rd, pok);
        mdl[0][64] = merge(mdl[0][64], 32'h00001234, 4'b0011);
        total++; if (rd !== last_rd[0]) begin bad++; $display("FAIL wr_keeps_data got=%h exp=%h", rd, last_rd[0]); end
        do_txn(1'b0, 32'h100, 4'h0, 32'h0, lat, err, both, rd, pok);
        total++; if (rd !== 32'hDEAB1234) begin bad++; $display("FAIL byte_lanes got=%h exp=deab1234", rd); end
        last_rd[0] = rd;
    endtask

    task automatic test_out_of_range();
        int lat; logic err, both, pok; logic [31:0] rd;
        do_txn(1'b0, 32'h000, 4'hF, 32'h55AA_33CC, lat, err, both, rd, pok);
        mdl[0][0] = 32'h55AA_33CC;
        do_txn(1'b0, 32'h000, 4'h0, 32'h0, lat, err, both, rd, pok);
        last_rd[0] = rd;
        do_txn(1'b0, 32'h1000, 4'hF, 32'h0BAD_0BAD, lat, err, both, rd, pok);
        total++; if (lat !== 1 || err !== 1'b1 || both !== 1'b0) begin bad++; $display("FAIL oor_error got lat=%0d err=%b both=%b exp lat=1 err=1", lat, err, both); end
        total++; if (pok !== 1'b1) begin bad++; $display("FAIL oor_pulse got=%b exp=1", pok); end
        total++; if (rd !== 32'h55AA_33CC) begin bad++; $display("FAIL oor_data_hold got=%h exp=55aa33cc", rd); end
        do_txn(1'b0, 32'h000, 4'h0, 32'h0, lat, err, both, rd, pok);
        total++; if (rd !== 32'h55AA_33CC || err !== 1'b0) begin bad++; $display("FAIL oor_no_write got=%h exp=55aa33cc", rd); end
        last_rd[0] = rd;
    endtask

    task automatic test_back_to_back();
        int lat; logic err, both, pok; logic [31:0] rd;
        logic [31:0] v4 = $urandom, v8 = $urandom;
        logic prev = 1'b0, exp_r;
        do_txn(1'b1, 32'h4, 4'hF, v4, lat, err, both, rd, pok);
        total++; if (lat !== 1) begin bad++; $display("FAIL ws0_latency got=%0d exp=1", lat); end
        do_txn(1'b1, 32'h8, 4'hF, v8, lat, err, both, rd, pok);
        mdl[1][1] = v4; mdl[1][2] = v8;
        @(negedge clk);
        use_ws0 = 1'b1; addr = 32'h4; wr = 4'h0; en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_r = (k % 2 == 1);
            total++; if (obs_ready !== exp_r) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, obs_ready, exp_r); end
            total++; if (prev && obs_ready) begin bad++; $display("FAIL b2b_consecutive k=%0d got=1 exp=0", k); end
            if (exp_r) begin
                total++; if (obs_data !== ((k == 1) ? v4 : v8)) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, obs_data, (k == 1) ? v4 : v8); end
            end
            prev = obs_ready;
            if (k == 1) addr = 32'h8;
        end
        en = 1'b0;
        last_rd[1] = v8;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        int lat; logic err, both, pok; logic [31:0] rd;
        @(negedge clk);
        use_ws0 = 1'b0; addr = 32'h100; wr = 4'hF; wdata = 32'h11111111; en = 1'b1;
        @(posedge clk); #1;
        total++; if (dbg2 !== 2'd1) begin bad++; $display("FAIL rst_pre_wait got=%0d exp=1", dbg2); end
        rst = 1'b1;
        #1;
        total++; if (b2.port_ready !== 1'b0 || b2.port_error !== 1'b0 || b2.port_data_o !== 32'd0 || dbg2 !== 2'd0)
            begin bad++; $display("FAIL rst_async got rdy=%b err=%b data=%h st=%0d exp 0", b2.port_ready, b2.port_error, b2.port_data_o, dbg2); end
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        do_txn(1'b0, 32'h100, 4'h0, 32'h0, lat, err, both, rd, pok);
        total++; if (rd !== 32'hDEAB1234) begin bad++; $display("FAIL rst_drop_write got=%h exp=deab1234", rd); end
        last_rd[0] = rd;
    endtask

    task automatic test_abort();
        int lat; logic err, both, pok; logic [31:0] rd;
        int seen = 0, at = 0;
        @(negedge clk);
        use_ws0 = 1'b0; addr = 32'h100; wr = 4'hF; wdata = 32'hCAFEF00D; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            if (b2.port_ready) begin seen++; at = k; end
        end
`ifdef ANTARES_MEM_ABORT_EN
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_ready got=%0d exp=0", seen); end
`else
        total++; if (seen !== 1 || at !== 3) begin bad++; $display("FAIL abort_ready got=%0d at=%0d exp=1 at=3", seen, at); end
        mdl[0][64] = 32'hCAFEF00D;
`endif
        total++; if (b2.port_data_o !== last_rd[0]) begin bad++; $display("FAIL abort_data_hold got=%h exp=%h", b2.port_data_o, last_rd[0]); end
        do_txn(1'b0, 32'h100, 4'h0, 32'h0, lat, err, both, rd, pok);
        total++; if (rd !== mdl[0][64]) begin bad++; $display("FAIL abort_mem got=%h exp=%h", rd, mdl[0][64]); end
        last_rd[0] = rd;
    endtask

    task automatic test_random();
        int lat; logic err, both, pok; logic [31:0] rd;
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 2; s++) begin
                logic [31:0] v = $urandom;
                do_txn(s[0], 32'((32 + i) * 4), 4'hF, v, lat, err, both, rd, pok);
                mdl[s][32 + i] = v;
            end
        end
        for (int n = 0; n < 40; n++) begin
            int s = $urandom_range(0, 1);
            int ix = 32 + $urandom_range(0, 15);
            int kind = $urandom_range(0, 9);
            logic [31:0] a = 32'(ix * 4) | 32'($urandom_range(0, 3));
            logic [3:0] w = (kind < 4) ? 4'h0 : 4'($urandom_range(1, 15));
            logic [31:0] d = $urandom;
            int exp_lat = (s == 1) ? 1 : 3;
            if (kind == 9) a = $urandom | 32'h0000_1000;
            do_txn(s[0], a, w, d, lat, err, both, rd, pok);
            total++; if (both !== 1'b0 || pok !== 1'b1) begin bad++; $display("FAIL rnd_pulse n=%0d both=%b single=%b exp 0/1", n, both, pok); end
            if (kind == 9) begin
                total++; if (err !== 1'b1 || lat !== 1 || rd !== last_rd[s]) begin bad++; $display("FAIL rnd_err n=%0d err=%b lat=%0d data=%h exp 1/1/%h", n, err, lat, rd, last_rd[s]); end
            end else if (w == 4'h0) begin
                total++; if (err !== 1'b0 || lat !== exp_lat || rd !== mdl[s][ix]) begin bad++; $display("FAIL rnd_read n=%0d lat=%0d data=%h exp lat=%0d data=%h", n, lat, rd, exp_lat, mdl[s][ix]); end
                last_rd[s] = mdl[s][ix];
            end else begin
                total++; if (err !== 1'b0 || lat !== exp_lat || rd !== last_rd[s]) begin bad++; $display("FAIL rnd_write n=%0d lat=%0d data=%h exp lat=%0d data=%h", n, lat, rd, exp_lat, last_rd[s]); end
                mdl[s][ix] = merge(mdl[s][ix], d, w);
            end
        end
    endtask

    initial begin
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst = 1'b0;
        test_word_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_wait();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
